updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised synchronous up/down modulo-N counter with parallel load, wrap or
//   saturate at the ends, and a one-shot mode that halts at the terminal value.
//   Next-generation general counter for the digital-systems lesson set; feeds
//   sequencers, timers and display drivers that need a counter of arbitrary modulus.
// PARAMETERS
//   WIDTH      3   count width in bits
//   MODULUS    8   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   RESET_VAL  0   count value after reset; must be < MODULUS
//   SATURATE   0   1: hold at the end value instead of wrapping (continuous mode only)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; one step per cycle while high
//   up_dn     in   1      1 = count up, 0 = count down; sampled every enabled cycle
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value for load
//   oneshot   in   1      1 = stop at the terminal value (HALT state)
//   count     out  WIDTH  registered count value
//   tc        out  1      combinational: en & ~halted & count at end value for up_dn
//   wrap      out  1      registered one-cycle pulse: the previous edge wrapped
//   halted    out  1      registered: FSM is in HALT
// BEHAVIOUR
//   End value: MODULUS-1 when counting up, 0 when counting down.
//   Priority at each clk edge: rst > load > en.
//   Reset: count=RESET_VAL, wrap=0, halted=0, state=RUN.
//   Load: count=load_val; if load_val >= MODULUS, count=MODULUS-1 (clamp).
//     Load forces state=RUN and wrap=0. It takes effect even when en=0.
//   FSM states: RUN, HALT.
//     RUN, en=1, count != end value: count +/- 1; wrap=0.
//     RUN, en=1, count == end value:
//       oneshot=1: count holds; state -> HALT; wrap=0.
//       oneshot=0, SATURATE=0: count -> 0 (up) or MODULUS-1 (down); wrap=1.
//       oneshot=0, SATURATE=1: count holds; wrap=0.
//     RUN, en=0: count holds; wrap=0.
//     HALT: count holds regardless of en/up_dn; tc=0.
//       Leaves HALT only on load (-> RUN) or rst (-> RUN).
//       oneshot falling while in HALT does not release it.
//   Direction reversal at the end value follows the current up_dn. Example: count=7,
//     up_dn=0 counts to 6; no wrap or halt.
//   Latency: count changes one cycle after the qualifying edge. wrap asserts in the
//     same cycle that count shows the wrapped value.
//   Arithmetic is modulo MODULUS, not 2**WIDTH. The counter never presents a value
//     >= MODULUS.
//   tc is combinational from registered state and en/up_dn only (no load path).
//   MODULUS=2**WIDTH: natural binary rollover must give identical results.
// TESTING
//   W=3,M=8: rst 2 cycles, en=1, up_dn=1 for 10 cycles -> 0..7,0,1; wrap=1 only with
//     count=0; tc=1 at count=7.
//   W=4,M=10: load 0, up_dn=0, en=1 -> 9,8,...; wrap pulses at count=9. Load 12 ->
//     count=9 (clamp).
//   W=4,M=10,SATURATE=1: load 7, up 5 cycles -> 8,9,9,9,9; wrap never asserts.
//     Down from 1 -> 0,0.
//   oneshot=1: load 5, up -> 6,7,8,9, then halted=1 and count holds at 9 for 4 more
//     en cycles with tc=0; load 2 -> RUN, count=2.
//   Simultaneous: rst+load+en in one cycle -> RESET_VAL. load+en -> load_val (no step).
//     rst during HALT -> RUN, RESET_VAL.
//   Reverse at end: count=9 (M=10), up_dn=0 -> 8 with no wrap. Toggle en mid-count
//     -> count holds exactly while en=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Synchronous up/down counter over the range 0..MODULUS-1.
//   It supports a parallel load, and it can wrap or saturate at either end.
//   A one-shot mode parks the counter at its terminal value until the next load
//   or reset.
//
// Parameters
//   WIDTH      count width in bits
//   MODULUS    number of count values (2 <= MODULUS <= 2**WIDTH)
//   RESET_VAL  count value after reset (< MODULUS)
//   SATURATE   1: hold at the end value instead of wrapping (continuous mode)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   en        in   count enable, one step per enabled cycle
//   up_dn     in   1 = count up, 0 = count down
//   load      in   parallel load strobe (works even with en low)
//   load_val  in   value to load, clamped to MODULUS-1
//   oneshot   in   1 = halt on reaching the end value instead of wrapping
//   count     out  registered count
//   tc        out  combinational terminal count: en & ~halted & count at end value
//   wrap      out  registered pulse, high while count shows a freshly wrapped value
//   halted    out  registered, high while the counter is parked in HALT
module updown_mod_counter #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  state_t           state;
  logic             atEnd;
  logic [WIDTH-1:0] clampedLoad;

  // The end value depends on the direction being asked for right now, so turning
  // around at MODULUS-1 or at 0 is an ordinary step and not a wrap. Loads above
  // the top of the range are pinned to MODULUS-1, which keeps every visible count
  // inside the modulus.
  always_comb begin
    atEnd       = up_dn ? (count == MaxVal) : (count == '0);
    clampedLoad = (load_val > MaxVal) ? MaxVal : load_val;
  end

  // Terminal count looks only at registered state and the live en/up_dn inputs.
  // Load does not feed into it, and it stays low while the counter is parked.
  assign tc     = en & ~halted & atEnd;
  assign halted = (state == HALT);

  // The counter and its FSM share one clocked block. Reset takes priority over
  // load, and load takes priority over counting. Steps away from the end value
  // cannot overflow because the end check comes first. That lets plain +1/-1 work
  // for any modulus, including MODULUS = 2**WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= ResetVal;
      wrap  <= 1'b0;
      state <= RUN;
    end else if (load) begin
      count <= clampedLoad;
      wrap  <= 1'b0;
      state <= RUN;
    end else begin
      wrap <= 1'b0;
      if (state == RUN && en) begin
        if (!atEnd) begin
          count <= up_dn ? (count + One) : (count - One);
        end else if (oneshot) begin
          state <= HALT;
        end else if (SATURATE == 0) begin
          count <= up_dn ? '0 : MaxVal;
          wrap  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
//   Drives three counter instances from one shared stimulus stream:
//     inst0: W=3, M=8 (natural binary rollover)
//     inst1: W=4, M=10, wrapping
//     inst2: W=4, M=10, saturating, RESET_VAL=3
//   Each instance is compared against an arithmetic reference model.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, oneshot;
  logic [3:0] load_val;

  logic [2:0] count0;
  logic [3:0] count1, count2;
  logic       tc0, tc1, tc2, wrap0, wrap1, wrap2, halted0, halted1, halted2;

  int errors = 0;
  int checks = 0;

  int modN[3]  = '{8, 10, 10};
  int widN[3]  = '{3, 4, 4};
  int satN[3]  = '{0, 0, 1};
  int rstN[3]  = '{0, 0, 3};

  int mCount[3];
  int mWrap[3];
  int mHalt[3];
  bit modelValid = 1'b0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[2:0]), .oneshot(oneshot),
    .count(count0), .tc(tc0), .wrap(wrap0), .halted(halted0)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .oneshot(oneshot),
    .count(count1), .tc(tc1), .wrap(wrap1), .halted(halted1)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3), .SATURATE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .oneshot(oneshot),
    .count(count2), .tc(tc2), .wrap(wrap2), .halted(halted2)
  );

  function automatic int obsCount(int i);
    case (i)
      0:       return int'(count0);
      1:       return int'(count1);
      default: return int'(count2);
    endcase
  endfunction

  function automatic int obsTc(int i);
    case (i)
      0:       return int'(tc0);
      1:       return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int obsWrap(int i);
    case (i)
      0:       return int'(wrap0);
      1:       return int'(wrap1);
      default: return int'(wrap2);
    endcase
  endfunction

  function automatic int obsHalt(int i);
    case (i)
      0:       return int'(halted0);
      1:       return int'(halted1);
      default: return int'(halted2);
    endcase
  endfunction

  // Expected terminal count: enabled, not parked, and sitting on the end value for
  // the requested direction.
  function automatic int expTc(int i);
    int endVal;
    endVal = up_dn ? modN[i] - 1 : 0;
    return (en && !mHalt[i] && mCount[i] == endVal) ? 1 : 0;
  endfunction

  // Reference model for one clock edge, written as modular arithmetic on integers.
  // A down step adds M-1 modulo M.
  task automatic modelStep(int i);
    int endVal, delta, lv;
    endVal = up_dn ? modN[i] - 1 : 0;
    delta  = up_dn ? 1 : modN[i] - 1;
    mWrap[i] = 0;
    if (rst) begin
      mCount[i] = rstN[i];
      mHalt[i]  = 0;
    end else if (load) begin
      lv        = int'(load_val) % (1 << widN[i]);
      mCount[i] = (lv >= modN[i]) ? modN[i] - 1 : lv;
      mHalt[i]  = 0;
    end else if (en && !mHalt[i]) begin
      if (mCount[i] != endVal) begin
        mCount[i] = (mCount[i] + delta) % modN[i];
      end else if (oneshot) begin
        mHalt[i] = 1;
      end else if (satN[i] == 0) begin
        mCount[i] = (mCount[i] + delta) % modN[i];
        mWrap[i]  = 1;
      end
    end
  endtask

  task automatic checkOutput(string tag, int inst, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s inst%0d: observed=%0d expected=%0d", tag, inst, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and check tc before the rising
  // edge. Then advance the model and check the registered outputs just after the
  // edge.
  task automatic applyStimulus(bit r, bit l, int lv, bit e, bit u, bit o);
    @(negedge clk);
    rst = r; load = l; load_val = 4'(lv); en = e; up_dn = u; oneshot = o;
    #1;
    if (modelValid) begin
      for (int i = 0; i < 3; i++) checkOutput("tc", i, obsTc(i), expTc(i));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    if (r) modelValid = 1'b1;
    #1;
    if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("count", i, obsCount(i), mCount[i]);
        checkOutput("wrap", i, obsWrap(i), mWrap[i]);
        checkOutput("halted", i, obsHalt(i), mHalt[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1; oneshot = 1'b0;

    $display("[TB] reset and free-running up count");
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("reset_val", 2, obsCount(2), 3);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 1, 1, 0);

    $display("[TB] load 0, count down through the wrap");
    applyStimulus(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 1, 0, 0);

    $display("[TB] load clamp");
    applyStimulus(0, 1, 12, 0, 1, 0);
    checkOutput("clamp", 1, obsCount(1), 9);
    checkOutput("clamp", 0, obsCount(0), 4);

    $display("[TB] saturating up and down");
    applyStimulus(0, 1, 7, 0, 1, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("sat_top", 2, obsCount(2), 9);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("sat_bottom", 2, obsCount(2), 0);

    $display("[TB] one-shot halt and release");
    applyStimulus(0, 1, 5, 0, 1, 1);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("oneshot_hold", 1, obsCount(1), 9);
    checkOutput("oneshot_halt", 1, obsHalt(1), 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 2, 1, 1, 0);
    checkOutput("release", 1, obsCount(1), 2);

    $display("[TB] simultaneous controls");
    applyStimulus(1, 1, 6, 1, 1, 0);
    applyStimulus(0, 1, 6, 1, 1, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 1, 1);

    $display("[TB] reverse at end value and enable toggling");
    applyStimulus(0, 1, 9, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("reverse", 1, obsCount(1), 8);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, k[0], 1, 0);

    $display("[TB] randomized stimulus");
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 10, $urandom_range(15),
                    $urandom_range(99) < 75, $urandom_range(1), $urandom_range(99) < 20);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
